// File: rtl/komut_kodlayici_pkg.sv
// Shared RV32I encoder definitions: opcode constants, legality check and field packing.
// The decoder imports the same opcode constants.
package komut_paket;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] komut;
    logic [31:0] adres;
  } kayit_t;

  // True when imm[31:n-1] are all equal, i.e. imm is representable as n-bit signed.
  function automatic logic sigar(input logic [31:0] imm, input int unsigned n);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << (n - 1);
    return ((imm & m) == m) || ((imm & m) == 32'd0);
  endfunction

  function automatic logic gecerli_mi(input logic [6:0] opcode, input logic [3:0] aluop,
                                      input logic [31:0] imm);
    logic [2:0] f3;
    logic       ok;
    f3 = aluop[2:0];
    ok = 1'b0;
    case (opcode)
      OP_R: ok = !aluop[3] || (f3 == 3'b000) || (f3 == 3'b101);
      OP_I: begin
        case (f3)
          3'b001:  ok = !aluop[3] && (imm[31:5] == 27'd0);
          3'b101:  ok = (imm[31:5] == 27'd0);
          default: ok = !aluop[3] && sigar(imm, 12);
        endcase
      end
      OP_LOAD:   ok = !aluop[3] && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111)
                      && sigar(imm, 12);
      OP_STORE:  ok = !aluop[3] && (f3 <= 3'b010) && sigar(imm, 12);
      OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011) && sigar(imm, 13) && !imm[0];
      OP_LUI:    ok = (imm[11:0] == 12'd0);
      OP_JAL:    ok = sigar(imm, 21) && !imm[0];
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] kodla(input logic [6:0] opcode, input logic [3:0] aluop,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd, input logic [31:0] imm);
    logic [2:0]  f3;
    logic [31:0] k;
    f3 = aluop[2:0];
    k  = 32'd0;
    case (opcode)
      OP_R: k = {1'b0, aluop[3], 5'b0, rs2, rs1, f3, rd, opcode};
      OP_I: begin
        // Shifts carry shamt in imm[4:0] and the arithmetic flag in bit 30.
        if ((f3 == 3'b001) || (f3 == 3'b101))
          k = {1'b0, aluop[3], 5'b0, imm[4:0], rs1, f3, rd, opcode};
        else
          k = {imm[11:0], rs1, f3, rd, opcode};
      end
      OP_LOAD:   k = {imm[11:0], rs1, f3, rd, opcode};
      OP_STORE:  k = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      OP_BRANCH: k = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
      OP_LUI:    k = {imm[31:12], rd, opcode};
      OP_JAL:    k = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:   k = 32'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/komut_fifo.sv
// First-word-fall-through FIFO; the head entry is always presented on cikis.
// Callers never push when full nor pop when empty.
module komut_fifo #(
  parameter int DERINLIK = 2,
  parameter int W        = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] giris,
  input  logic         pop,
  output logic [W-1:0] cikis,
  output logic         dolu,
  output logic         bos
);
  localparam int AW = $clog2(DERINLIK);

  logic [DERINLIK-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]              bas_q, bas_d, kuy_q, kuy_d;
  logic [AW:0]                say_q, say_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[kuy_q] = giris;
    kuy_d = kuy_q + AW'(push);
    bas_d = bas_q + AW'(pop);
    say_d = say_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      bas_q <= '0;
      kuy_q <= '0;
      say_q <= '0;
    end else begin
      mem_q <= mem_d;
      bas_q <= bas_d;
      kuy_q <= kuy_d;
      say_q <= say_d;
    end
  end

  assign cikis = mem_q[bas_q];
  assign dolu  = (say_q == (AW+1)'(DERINLIK));
  assign bos   = (say_q == '0);
endmodule

// File: rtl/komut_kodlayici.sv
// RV32I instruction encoder: checks and packs decoded fields into a 32-bit word,
// tags it with its program address and queues it toward instruction memory.
module komut_kodlayici
  import komut_paket::*;
#(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000,
  parameter int          DERINLIK        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        giris_gecerli,
  output logic        giris_hazir,
  input  logic [6:0]  opcode,
  input  logic [3:0]  aluop,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        cikis_gecerli,
  input  logic        cikis_hazir,
  output logic [31:0] komut,
  output logic [31:0] adres,
  output logic        hata,
  output logic [7:0]  hata_sayac
);
  logic        kabul, yasal, push, pop, dolu, bos;
  kayit_t      giris_kayit, cikis_kayit;
  logic [31:0] adres_sayac_q, adres_sayac_d;
  logic        hata_q, hata_d;
  logic [7:0]  hata_sayac_q, hata_sayac_d;

  always_comb begin
    kabul       = giris_gecerli && giris_hazir;
    yasal       = gecerli_mi(opcode, aluop, imm);
    push        = kabul && yasal;
    pop         = cikis_gecerli && cikis_hazir;
    giris_kayit = '{komut: kodla(opcode, aluop, rs1, rs2, rd, imm), adres: adres_sayac_q};
    adres_sayac_d = push ? adres_sayac_q + 32'd4 : adres_sayac_q;
    hata_d        = kabul && !yasal;
    hata_sayac_d  = (hata_d && (hata_sayac_q != 8'hFF)) ? hata_sayac_q + 8'd1 : hata_sayac_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adres_sayac_q <= BASLANGIC_ADRES;
      hata_q        <= 1'b0;
      hata_sayac_q  <= 8'd0;
    end else begin
      adres_sayac_q <= adres_sayac_d;
      hata_q        <= hata_d;
      hata_sayac_q  <= hata_sayac_d;
    end
  end

  komut_fifo #(.DERINLIK(DERINLIK), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .giris (giris_kayit),
    .pop   (pop),
    .cikis (cikis_kayit),
    .dolu  (dolu),
    .bos   (bos)
  );

  // Readiness comes from registered FIFO occupancy only, never from cikis_hazir.
  assign giris_hazir   = !dolu;
  assign cikis_gecerli = !bos;
  assign komut         = cikis_kayit.komut;
  assign adres         = cikis_kayit.adres;
  assign hata          = hata_q;
  assign hata_sayac    = hata_sayac_q;
endmodule

// File: tb/tb_komut_kodlayici.sv
// Bench for komut_kodlayici: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an arithmetic reference model with a word queue.
module tb_komut_kodlayici;
  localparam logic [31:0] BASL = 32'h0000_0000;

  logic        clk, rst, giris_gecerli, giris_hazir, cikis_gecerli, cikis_hazir, hata;
  logic [6:0]  opcode;
  logic [3:0]  aluop;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, komut, adres;
  logic [7:0]  hata_sayac;

  komut_kodlayici #(.BASLANGIC_ADRES(BASL), .DERINLIK(2)) dut (
    .clk(clk), .rst(rst), .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .opcode(opcode), .aluop(aluop), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir), .komut(komut),
    .adres(adres), .hata(hata), .hata_sayac(hata_sayac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_fits(input logic [31:0] v, input int n);
    longint s;
    s = longint'($signed(v));
    return (s >= -(longint'(1) << (n - 1))) && (s < (longint'(1) << (n - 1)));
  endfunction

  function automatic bit m_legal(input logic [6:0] op, input logic [3:0] al, input logic [31:0] v);
    int f3;
    bit a3;
    f3 = int'(al[2:0]);
    a3 = al[3];
    case (op)
      7'h33: return !a3 || f3 == 0 || f3 == 5;
      7'h13: begin
        if (f3 == 1) return !a3 && v < 32;
        if (f3 == 5) return v < 32;
        return !a3 && m_fits(v, 12);
      end
      7'h03: return !a3 && (f3 inside {0, 1, 2, 4, 5}) && m_fits(v, 12);
      7'h23: return !a3 && f3 <= 2 && m_fits(v, 12);
      7'h63: return f3 != 2 && f3 != 3 && m_fits(v, 13) && (v % 2 == 0);
      7'h37: return v % 4096 == 0;
      7'h6F: return m_fits(v, 21) && (v % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_enc(input logic [6:0] op, input logic [3:0] al,
                                        input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] d, input logic [31:0] v);
    logic [31:0] o, f3, a3, r1, r2, rdv;
    o = 32'(op); f3 = 32'(al[2:0]); a3 = 32'(al[3]);
    r1 = 32'(a); r2 = 32'(b); rdv = 32'(d);
    case (op)
      7'h33: return o + rdv * 128 + f3 * 4096 + r1 * 32768 + r2 * (1 << 20) + a3 * (1 << 30);
      7'h13: begin
        if (f3 == 1 || f3 == 5)
          return o + rdv * 128 + f3 * 4096 + r1 * 32768 + (v % 32) * (1 << 20) + a3 * (1 << 30);
        return o + rdv * 128 + f3 * 4096 + r1 * 32768 + (v % 4096) * (1 << 20);
      end
      7'h03: return o + rdv * 128 + f3 * 4096 + r1 * 32768 + (v % 4096) * (1 << 20);
      7'h23: return o + (v % 32) * 128 + f3 * 4096 + r1 * 32768 + r2 * (1 << 20)
                    + ((v / 32) % 128) * (1 << 25);
      7'h63: return o + ((v / 2048) % 2) * 128 + ((v / 2) % 16) * 256 + f3 * 4096
                    + r1 * 32768 + r2 * (1 << 20) + ((v / 32) % 64) * (1 << 25)
                    + ((v / 4096) % 2) * (1 << 31);
      7'h37: return o + rdv * 128 + (v / 4096) * 4096;
      7'h6F: return o + rdv * 128 + ((v / 4096) % 256) * 4096 + ((v / 2048) % 2) * (1 << 20)
                    + ((v / 2) % 1024) * (1 << 21) + ((v / (1 << 20)) % 2) * (1 << 31);
      default: return 32'd0;
    endcase
  endfunction

  task automatic sur(input logic [6:0] o, input logic [3:0] a, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [4:0] d, input logic [31:0] v);
    opcode = o; aluop = a; rs1 = s1; rs2 = s2; rd = d; imm = v;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; giris_gecerli = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [3:0]  al;
    logic [4:0]  s1, s2, d;
    logic [31:0] v;
    bit          legal;
    logic [31:0] k;
  } vec_t;

  vec_t tbl[15];
  logic [63:0] q[$];
  logic [31:0] exp_adr, w1, w2, w3, e;
  int errs;
  bit acc, lg, pp, m_hata;
  int m_err;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{7'h63, 4'h0, 5'd1, 5'd2, 5'd0, 32'd3,         1'b0, 32'h0};
    tbl[1]  = '{7'h13, 4'h8, 5'd1, 5'd0, 5'd2, 32'd5,         1'b0, 32'h0};
    tbl[2]  = '{7'h7F, 4'h0, 5'd1, 5'd2, 5'd3, 32'd0,         1'b0, 32'h0};
    tbl[3]  = '{7'h33, 4'h0, 5'd1, 5'd2, 5'd3, 32'd0,         1'b1, 32'h002081B3};
    tbl[4]  = '{7'h33, 4'h8, 5'd1, 5'd2, 5'd3, 32'd0,         1'b1, 32'h402081B3};
    tbl[5]  = '{7'h13, 4'h0, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF,  1'b1, 32'hFFF00293};
    tbl[6]  = '{7'h37, 4'h0, 5'd0, 5'd0, 5'd1, 32'h12345000,  1'b1, 32'h123450B7};
    tbl[7]  = '{7'h23, 4'h2, 5'd1, 5'd2, 5'd0, 32'd8,         1'b1, 32'h0020A423};
    tbl[8]  = '{7'h63, 4'h0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC,  1'b1, 32'hFE208EE3};
    tbl[9]  = '{7'h6F, 4'h0, 5'd0, 5'd0, 5'd1, 32'd8,         1'b1, 32'h008000EF};
    tbl[10] = '{7'h13, 4'hD, 5'd2, 5'd0, 5'd1, 32'd3,         1'b1, 32'h40315093};
    tbl[11] = '{7'h03, 4'h3, 5'd1, 5'd0, 5'd2, 32'd0,         1'b0, 32'h0};
    tbl[12] = '{7'h13, 4'h1, 5'd1, 5'd0, 5'd2, 32'd32,        1'b0, 32'h0};
    tbl[13] = '{7'h13, 4'h0, 5'd1, 5'd0, 5'd2, 32'd2048,      1'b0, 32'h0};
    tbl[14] = '{7'h6F, 4'h0, 5'd0, 5'd0, 5'd1, 32'd1,         1'b0, 32'h0};

    rst = 1'b1; giris_gecerli = 1'b0; cikis_hazir = 1'b1;
    sur(7'h0, 4'h0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_giris_hazir", 32'(giris_hazir), 32'd1);
    chk("rst_cikis_gecerli", 32'(cikis_gecerli), 32'd0);
    chk("rst_komut", komut, 32'd0);
    chk("rst_adres", adres, 32'd0);
    chk("rst_hata", 32'(hata), 32'd0);
    chk("rst_hata_sayac", 32'(hata_sayac), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed table, one bundle per cycle with the consumer always ready.
    exp_adr = BASL; errs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      sur(tbl[i].op, tbl[i].al, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].v);
      giris_gecerli = 1'b1;
      @(posedge clk); #1;
      giris_gecerli = 1'b0;
      if (!tbl[i].legal) errs++;
      chk($sformatf("vec%0d_hata", i), 32'(hata), 32'(!tbl[i].legal));
      chk($sformatf("vec%0d_cikis_gecerli", i), 32'(cikis_gecerli), 32'(tbl[i].legal));
      chk($sformatf("vec%0d_hata_sayac", i), 32'(hata_sayac), 32'(errs));
      if (tbl[i].legal) begin
        chk($sformatf("vec%0d_komut", i), komut, tbl[i].k);
        chk($sformatf("vec%0d_adres", i), adres, exp_adr);
        exp_adr = exp_adr + 32'd4;
      end
    end

    // Backpressure: FIFO fills at two, third bundle waits, order preserved.
    do_reset();
    cikis_hazir = 1'b0;
    w1 = m_enc(7'h13, 4'h0, 5'd0, 5'd0, 5'd1, 32'd1);
    w2 = m_enc(7'h13, 4'h0, 5'd0, 5'd0, 5'd2, 32'd2);
    w3 = m_enc(7'h13, 4'h0, 5'd0, 5'd0, 5'd3, 32'd3);
    @(negedge clk); sur(7'h13, 4'h0, 5'd0, 5'd0, 5'd1, 32'd1); giris_gecerli = 1'b1;
    @(posedge clk); #1;
    chk("bp_hazir_after1", 32'(giris_hazir), 32'd1);
    chk("bp_gecerli_after1", 32'(cikis_gecerli), 32'd1);
    @(negedge clk); sur(7'h13, 4'h0, 5'd0, 5'd0, 5'd2, 32'd2);
    @(posedge clk); #1;
    chk("bp_hazir_after2", 32'(giris_hazir), 32'd0);
    @(negedge clk); sur(7'h13, 4'h0, 5'd0, 5'd0, 5'd3, 32'd3);
    @(posedge clk); #1;
    chk("bp_hazir_held", 32'(giris_hazir), 32'd0);
    chk("bp_komut_stable", komut, w1);
    chk("bp_adres_stable", adres, 32'd0);
    @(negedge clk); cikis_hazir = 1'b1;
    @(posedge clk); #1;
    chk("bp_komut_2", komut, w2);
    chk("bp_adres_2", adres, 32'd4);
    chk("bp_hazir_reopen", 32'(giris_hazir), 32'd1);
    @(posedge clk); #1;
    giris_gecerli = 1'b0;
    chk("bp_komut_3", komut, w3);
    chk("bp_adres_3", adres, 32'd8);
    chk("bp_gecerli_3", 32'(cikis_gecerli), 32'd1);
    @(posedge clk); #1;
    chk("bp_drained", 32'(cikis_gecerli), 32'd0);

    // Reset with a full FIFO and a same-cycle acceptance attempt.
    cikis_hazir = 1'b0;
    @(negedge clk); sur(7'h7F, 4'h0, 5'd0, 5'd0, 5'd0, 32'd0); giris_gecerli = 1'b1;
    @(negedge clk); sur(7'h33, 4'h0, 5'd1, 5'd2, 5'd3, 32'd0);
    @(negedge clk); sur(7'h33, 4'h0, 5'd4, 5'd5, 5'd6, 32'd0);
    @(negedge clk); giris_gecerli = 1'b0;
    #1;
    chk("mr_pre_sayac", 32'(hata_sayac), 32'd1);
    chk("mr_pre_full", 32'(giris_hazir), 32'd0);
    @(negedge clk); rst = 1'b1; giris_gecerli = 1'b1;
    @(posedge clk); #1;
    chk("mr_gecerli", 32'(cikis_gecerli), 32'd0);
    chk("mr_sayac", 32'(hata_sayac), 32'd0);
    chk("mr_hazir", 32'(giris_hazir), 32'd1);
    @(negedge clk); rst = 1'b0; cikis_hazir = 1'b1;
    sur(7'h33, 4'h0, 5'd1, 5'd2, 5'd3, 32'd0);
    @(posedge clk); #1;
    giris_gecerli = 1'b0;
    chk("mr_next_adres", adres, BASL);
    chk("mr_next_komut", komut, 32'h002081B3);

    // Saturation of the error counter.
    @(negedge clk); sur(7'h7F, 4'h0, 5'd0, 5'd0, 5'd0, 32'd0); giris_gecerli = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    giris_gecerli = 1'b0;
    chk("sat_sayac", 32'(hata_sayac), 32'd255);
    chk("sat_hata", 32'(hata), 32'd1);
    chk("sat_no_push", 32'(cikis_gecerli), 32'd0);

    // Randomized traffic against the queue model.
    do_reset();
    q.delete(); exp_adr = BASL; m_hata = 1'b0; m_err = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      chk("rnd_giris_hazir", 32'(giris_hazir), 32'(q.size() < 2));
      chk("rnd_cikis_gecerli", 32'(cikis_gecerli), 32'(q.size() != 0));
      chk("rnd_hata", 32'(hata), 32'(m_hata));
      chk("rnd_hata_sayac", 32'(hata_sayac), 32'(m_err));
      if (q.size() != 0) begin
        chk("rnd_komut", komut, q[0][63:32]);
        chk("rnd_adres", adres, q[0][31:0]);
      end
      case ($urandom_range(0, 7))
        0: opcode = 7'h33; 1: opcode = 7'h13; 2: opcode = 7'h03; 3: opcode = 7'h23;
        4: opcode = 7'h63; 5: opcode = 7'h37; 6: opcode = 7'h6F;
        default: opcode = 7'($urandom);
      endcase
      aluop = 4'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 40));
        2: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      giris_gecerli = ($urandom_range(0, 3) != 0);
      cikis_hazir   = ($urandom_range(0, 2) != 0);
      acc = giris_gecerli && (q.size() < 2);
      lg  = m_legal(opcode, aluop, imm);
      pp  = (q.size() != 0) && cikis_hazir;
      e   = m_enc(opcode, aluop, rs1, rs2, rd, imm);
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (acc && lg) begin
        q.push_back({e, exp_adr});
        exp_adr = exp_adr + 32'd4;
      end
      m_hata = acc && !lg;
      if (m_hata && m_err < 255) m_err++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/komut_kodlayici.md
# komut_kodlayici

Sequential RV32I instruction encoder: the inverse of the instruction decoder. It accepts decoded instruction fields (opcode, aluop, rs1, rs2, rd, imm), checks their legality, packs them into a 32-bit instruction word and emits that word with its program address.

It sits between the test-program generator and instruction memory. A 2-entry output FIFO lets the memory writer apply backpressure, and illegal field bundles are rejected with an error pulse and counter.

## Interface

Parameters:
- BASLANGIC_ADRES, 32'h0000_0000, address assigned to the first legal instruction after reset.
- DERINLIK, 2, output FIFO depth in entries (power of two, ≥2).

Ports:
- clk  in  1  clock; everything is synchronous to the rising edge.
- rst  in  1  synchronous, active-high reset.
- giris_gecerli  in  1  field bundle valid.
- giris_hazir  out  1  encoder can accept a bundle.
- opcode  in  7  RV32I major opcode.
- aluop  in  4  {funct7[5], funct3}, same packing as the decoder.
- rs1, rs2, rd  in  5 each  register indices.
- imm  in  32  sign-extended immediate, byte offset for B/J formats.
- cikis_gecerli  out  1  encoded word available.
- cikis_hazir  in  1  consumer accepts the word.
- komut  out  32  encoded instruction.
- adres  out  32  program address of komut.
- hata  out  1  one-cycle pulse: illegal bundle rejected.
- hata_sayac  out  8  count of rejected bundles, saturates at 255.

## Operation

- Acceptance: a bundle is accepted on an edge where giris_gecerli && giris_hazir. giris_hazir = (FIFO count < DERINLIK), registered-state based, with no combinational path from cikis_hazir.
- Encoding is combinational on the input fields. An accepted legal bundle is pushed as {komut, adres_sayac}, then adres_sayac += 4, wrapping modulo 2^32.
- An accepted illegal bundle is not pushed and adres_sayac is unchanged. hata = 1 in the following cycle and hata_sayac increments (stays at 255 when saturated).
- Formats and legality; any other opcode is illegal:
  - 0110011 R-type: {0, aluop[3], 00000, rs2, rs1, aluop[2:0], rd, opcode}. aluop[3]=1 is legal only with funct3 000 or 101.
  - 0010011 I-ALU: funct3 = aluop[2:0].
    - For funct3 001/101, imm must be in 0..31 and is encoded as imm[11:5] = {0, aluop[3], 00000}. aluop[3]=1 is legal only with funct3 101.
    - For other funct3 values, aluop[3] must be 0 and imm must fit 12-bit signed.
  - 0000011 load: funct3 ∈ {000, 001, 010, 100, 101}; 12-bit signed imm; aluop[3]=0.
  - 0100011 store (S): funct3 ∈ {000, 001, 010}; 12-bit signed imm; aluop[3]=0.
  - 1100011 branch (B): funct3 ∈ {000, 001, 100, 101, 110, 111}; imm must fit 13-bit signed with imm[0]=0.
  - 0110111 LUI (U): imm[11:0] must be 0; aluop is ignored.
  - 1101111 JAL (J): imm must fit 21-bit signed with imm[0]=0; aluop is ignored.
- "Fits N-bit signed" means imm[31:N-1] are all equal.
- Fields a format does not use (rs2 for I-type, rd for S/B, and so on) are ignored and do not appear in komut.
- FIFO: it is first-word-fall-through; the head entry drives komut and adres, and cikis_gecerli = (count ≠ 0). A pop occurs on cikis_gecerli && cikis_hazir.
- Simultaneous push and pop keeps the count unchanged. The FIFO never pushes when full because giris_hazir is low.

## Timing

- Reset values:
  - giris_hazir = 1
  - cikis_gecerli = 0
  - komut = 0
  - adres = 0
  - hata = 0
  - hata_sayac = 0
  - FIFO count = 0
  - adres_sayac = BASLANGIC_ADRES
- rst has priority over all other events. Reset mid-stream discards FIFO contents and any same-cycle acceptance.
- Latency: the word is visible (cikis_gecerli = 1) one cycle after the accepting edge when the FIFO was empty.
- Throughput: one instruction per cycle while cikis_hazir = 1.
- hata asserts exactly one cycle after the rejecting edge and never coincides with a push for the same bundle.
- While cikis_gecerli = 1 and cikis_hazir = 0, komut and adres hold stable.

## Structure

- Shared package komut_paket holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL);
  - the legality function `gecerli_mi(opcode, aluop, imm)`;
  - the packing function `kodla(...)`.
  The decoder reuses the same opcode constants.
- Sub-module komut_fifo holds the parameterised FWFT FIFO (head/tail pointers, count, full/empty). The top level keeps the encode logic, address counter and error logic.

## Test plan

- ADD x3,x1,x2 (opcode 0110011, aluop 0000, rs1=1, rs2=2, rd=3) -> next cycle komut=32'h002081B3, adres=0. SUB with aluop 1000 -> 32'h402081B3, adres=4.
- ADDI x5,x0,-1 (opcode 0010011, aluop 0000, rd=5, imm=32'hFFFFFFFF) -> 32'h FFF00293. LUI x1 with imm=32'h12345000 -> 32'h123450B7.
- Illegal bundles must pulse hata one cycle later, leave hata_sayac=3 and push nothing:
  - branch (1100011, aluop 0000) with imm=3, which is odd;
  - I-type with aluop 1000, which is illegal;
  - opcode 1111111.
  The next legal instruction gets adres 0.
- Backpressure: hold cikis_hazir=0 and push 3 legal bundles.
  - giris_hazir drops after 2 pushes and the third is held.
  - Release cikis_hazir; words come out in order with adres 0, 4, 8 and none are lost.
- Assert rst while the FIFO holds 2 entries -> the next cycle has cikis_gecerli=0, hata_sayac=0, and the next legal instruction gets adres=BASLANGIC_ADRES.
- Push 256 illegal bundles -> hata_sayac saturates at 255.
